// File: rtl/axi_read_arbiter_if.sv
// axi_read_arbiter_if: requester ports and AXI read channels of the arbiter.
interface axi_read_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [7:0]  i_len;
  logic        i_gnt;
  logic [31:0] i_rdata;
  logic        i_rvalid;
  logic        i_rlast;
  logic        d_req;
  logic [31:0] d_addr;
  logic [7:0]  d_len;
  logic        d_gnt;
  logic [31:0] d_rdata;
  logic        d_rvalid;
  logic        d_rlast;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        busy;
  logic        err;
  modport master (
    input  i_req, i_addr, i_len, d_req, d_addr, d_len, arready, rid, rdata, rresp, rlast, rvalid,
    output i_gnt, i_rdata, i_rvalid, i_rlast, d_gnt, d_rdata, d_rvalid, d_rlast,
           arid, araddr, arlen, arsize, arburst, arvalid, rready, busy, err
  );
  modport slave (
    output i_req, i_addr, i_len, d_req, d_addr, d_len, arready, rid, rdata, rresp, rlast, rvalid,
    input  i_gnt, i_rdata, i_rvalid, i_rlast, d_gnt, d_rdata, d_rvalid, d_rlast,
           arid, araddr, arlen, arsize, arburst, arvalid, rready, busy, err
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: two-requester AXI read arbiter, data side favoured with a starvation cap for instruction side.
module axi_read_arbiter #(
  parameter int MAX_STREAK = 4
) (
  input logic             aclk,
  input logic             aresetn,
  axi_read_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  localparam logic [2:0] MAX = 3'(MAX_STREAK);
  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  streak_q, streak_d;
  logic        pick_i, hs, beat;
  assign pick_i = bus.i_req && (!bus.d_req || streak_q == MAX);
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    len_d    = len_q;
    streak_d = streak_q;
    case (state_q)
      IDLE: if (bus.i_req || bus.d_req) begin
        owner_d  = !pick_i;
        addr_d   = pick_i ? bus.i_addr : bus.d_addr;
        len_d    = pick_i ? bus.i_len : bus.d_len;
        streak_d = (!pick_i && bus.i_req) ? ((streak_q == MAX) ? MAX : streak_q + 3'd1) : 3'd0;
        state_d  = ADDR;
      end
      ADDR:    state_d = bus.arready ? DATA : ADDR;
      DATA:    state_d = (bus.rvalid && bus.rlast) ? IDLE : DATA;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      streak_q <= streak_d;
    end
  end
  // owner_q = 1 means the data side holds the bus; it doubles as the AXI id
  assign bus.arvalid  = state_q == ADDR;
  assign bus.araddr   = addr_q;
  assign bus.arlen    = len_q;
  assign bus.arid     = {3'b000, owner_q};
  assign bus.arsize   = 3'b010;
  assign bus.arburst  = 2'b01;
  assign bus.rready   = state_q == DATA;
  assign bus.busy     = aresetn && state_q != IDLE;
  assign hs           = aresetn && bus.arvalid && bus.arready;
  assign bus.i_gnt    = hs && !owner_q;
  assign bus.d_gnt    = hs && owner_q;
  assign beat         = aresetn && state_q == DATA && bus.rvalid;
  assign bus.i_rvalid = beat && !owner_q;
  assign bus.i_rlast  = beat && !owner_q && bus.rlast;
  assign bus.i_rdata  = owner_q ? 32'd0 : bus.rdata;
  assign bus.d_rvalid = beat && owner_q;
  assign bus.d_rlast  = beat && owner_q && bus.rlast;
  assign bus.d_rdata  = owner_q ? bus.rdata : 32'd0;
  assign bus.err      = beat && (bus.rresp != 2'b00 || bus.rid != bus.arid);
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed checks of arbitration, routing, error, starvation and reset behaviour.
`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      failures++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); \
    end \
  end

module tb_axi_read_arbiter;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int   checks = 0;
  int   failures = 0;
  axi_read_arbiter_if bus();
  axi_read_arbiter #(.MAX_STREAK(4)) dut (.aclk(aclk), .aresetn(aresetn), .bus(bus));
  always #5 aclk = ~aclk;
  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  task automatic handshake(input logic is_d, input logic [31:0] addr, input logic [7:0] len, input logic drop);
    `CHK("ar_valid", bus.arvalid, 1'b1)
    `CHK("ar_addr", bus.araddr, addr)
    `CHK("ar_len", bus.arlen, len)
    `CHK("ar_id", bus.arid, {3'b000, is_d})
    `CHK("ar_size", bus.arsize, 3'b010)
    `CHK("ar_burst", bus.arburst, 2'b01)
    `CHK("busy_addr", bus.busy, 1'b1)
    bus.arready = 1'b1;
    settle();
    `CHK("gnt_owner", is_d ? bus.d_gnt : bus.i_gnt, 1'b1)
    `CHK("gnt_other", is_d ? bus.i_gnt : bus.d_gnt, 1'b0)
    cyc();
    bus.arready = 1'b0;
    if (drop) begin
      if (is_d) bus.d_req = 1'b0;
      else bus.i_req = 1'b0;
    end
    settle();
    `CHK("data_rready", bus.rready, 1'b1)
    `CHK("data_arvalid", bus.arvalid, 1'b0)
    `CHK("data_gnt", bus.i_gnt | bus.d_gnt, 1'b0)
  endtask
  task automatic burst(input logic is_d, input int n, input int total, input logic [3:0] id,
                       input int err_beat, input int bad_id_beat, input logic [31:0] base);
    for (int b = 0; b < n; b++) begin
      bus.rvalid = 1'b1;
      bus.rdata  = base + 32'(b);
      bus.rlast  = (b == total - 1);
      bus.rresp  = (b == err_beat) ? 2'b10 : 2'b00;
      bus.rid    = (b == bad_id_beat) ? (id ^ 4'd1) : id;
      settle();
      checks++;
      if ((is_d ? bus.d_rvalid : bus.i_rvalid) !== 1'b1) begin
        failures++;
        $error("FAIL own_rvalid beat=%0d", b);
      end
      checks++;
      if ((is_d ? bus.d_rdata : bus.i_rdata) !== base + 32'(b)) begin
        failures++;
        $error("FAIL own_rdata beat=%0d", b);
      end
      checks++;
      if ((is_d ? bus.d_rlast : bus.i_rlast) !== (b == total - 1)) begin
        failures++;
        $error("FAIL own_rlast beat=%0d", b);
      end
      checks++;
      if ((is_d ? bus.i_rvalid : bus.d_rvalid) !== 1'b0) begin
        failures++;
        $error("FAIL oth_rvalid beat=%0d", b);
      end
      checks++;
      if ((is_d ? bus.i_rlast : bus.d_rlast) !== 1'b0) begin
        failures++;
        $error("FAIL oth_rlast beat=%0d", b);
      end
      checks++;
      if (bus.err !== ((b == err_beat) || (b == bad_id_beat))) begin
        failures++;
        $error("FAIL err beat=%0d observed=%0h", b, bus.err);
      end
      cyc();
    end
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    bus.rresp  = 2'b00;
    bus.rid    = 4'd0;
    settle();
  endtask
  initial begin
    bus.i_req = 1'b0; bus.i_addr = '0; bus.i_len = '0;
    bus.d_req = 1'b0; bus.d_addr = '0; bus.d_len = '0;
    bus.arready = 1'b0; bus.rid = '0; bus.rdata = '0; bus.rresp = '0;
    bus.rlast = 1'b0; bus.rvalid = 1'b0;
    cyc();
    bus.i_req = 1'b1;
    bus.rvalid = 1'b1;
    cyc();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $error("FAIL rst_busy observed=%0h expected=0", bus.busy);
    end
    `CHK("rst_arvalid", bus.arvalid, 1'b0)
    `CHK("rst_rready", bus.rready, 1'b0)
    `CHK("rst_araddr", bus.araddr, 32'd0)
    `CHK("rst_arlen", bus.arlen, 8'd0)
    `CHK("rst_arid", bus.arid, 4'd0)
    `CHK("rst_gnt", bus.i_gnt | bus.d_gnt, 1'b0)
    `CHK("rst_rvalid", bus.i_rvalid | bus.d_rvalid, 1'b0)
    `CHK("rst_rlast", bus.i_rlast | bus.d_rlast, 1'b0)
    `CHK("rst_err", bus.err, 1'b0)
    bus.rvalid = 1'b0;
    aresetn = 1'b1;
    bus.i_addr = 32'h1FC0_0000;
    bus.i_len = 8'd7;
    settle();
    `CHK("idle_busy", bus.busy, 1'b0)
    cyc();
    `CHK("wait1_arvalid", bus.arvalid, 1'b1)
    `CHK("wait1_gnt", bus.i_gnt, 1'b0)
    cyc();
    `CHK("wait2_araddr", bus.araddr, 32'h1FC0_0000)
    checks++;
    if (bus.i_gnt !== 1'b0) begin
      failures++;
      $error("FAIL wait2_gnt observed=%0h expected=0", bus.i_gnt);
    end
    handshake(1'b0, 32'h1FC0_0000, 8'd7, 1'b1);
    burst(1'b0, 8, 8, 4'd0, -1, -1, 32'hA0);
    `CHK("single_done_busy", bus.busy, 1'b0)
    `CHK("single_done_rready", bus.rready, 1'b0)
    bus.i_req = 1'b1; bus.i_addr = 32'h100; bus.i_len = 8'd1;
    bus.d_req = 1'b1; bus.d_addr = 32'h200; bus.d_len = 8'd0;
    cyc();
    handshake(1'b1, 32'h200, 8'd0, 1'b1);
    burst(1'b1, 1, 1, 4'd1, -1, -1, 32'hB0);
    `CHK("bubble_busy", bus.busy, 1'b0)
    `CHK("bubble_arvalid", bus.arvalid, 1'b0)
    cyc();
    handshake(1'b0, 32'h100, 8'd1, 1'b1);
    burst(1'b0, 2, 2, 4'd0, -1, -1, 32'hC0);
    bus.i_req = 1'b1; bus.i_addr = 32'h400; bus.i_len = 8'd0;
    bus.d_req = 1'b1; bus.d_addr = 32'h500; bus.d_len = 8'd0;
    for (int g = 0; g < 5; g++) begin
      cyc();
      handshake(g < 4, (g < 4) ? 32'h500 : 32'h400, 8'd0, 1'b0);
      `CHK("streak", dut.streak_q, (g < 4) ? 3'(g + 1) : 3'd0)
      if (g == 4) begin
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
      end
      burst(g < 4, 1, 1, (g < 4) ? 4'd1 : 4'd0, -1, -1, 32'hD0 + 32'(g));
    end
    `CHK("starve_idle", bus.busy, 1'b0)
    bus.d_req = 1'b1; bus.d_addr = 32'h300; bus.d_len = 8'd3;
    cyc();
    handshake(1'b1, 32'h300, 8'd3, 1'b1);
    burst(1'b1, 4, 4, 4'd1, 2, -1, 32'hE0);
    bus.i_req = 1'b1; bus.i_addr = 32'h800; bus.i_len = 8'd1;
    cyc();
    handshake(1'b0, 32'h800, 8'd1, 1'b1);
    burst(1'b0, 2, 2, 4'd0, -1, 0, 32'hF0);
    bus.i_req = 1'b1; bus.i_addr = 32'h700; bus.i_len = 8'd7;
    cyc();
    handshake(1'b0, 32'h700, 8'd7, 1'b1);
    burst(1'b0, 2, 8, 4'd0, -1, -1, 32'h70);
    `CHK("mid_busy", bus.busy, 1'b1)
    bus.rvalid = 1'b1; bus.rdata = 32'h72;
    aresetn = 1'b0;
    settle();
    `CHK("rst_mid_rvalid", bus.i_rvalid, 1'b0)
    cyc();
    `CHK("rst_mid_busy", bus.busy, 1'b0)
    `CHK("rst_mid_rready", bus.rready, 1'b0)
    `CHK("rst_mid_rvalid2", bus.i_rvalid | bus.d_rvalid, 1'b0)
    aresetn = 1'b1;
    settle();
    `CHK("post_rst_rvalid", bus.i_rvalid | bus.d_rvalid, 1'b0)
    bus.rvalid = 1'b0;
    bus.arready = 1'b1;
    bus.d_req = 1'b1; bus.d_addr = 32'h600; bus.d_len = 8'd0;
    settle();
    `CHK("len0_idle_gnt", bus.d_gnt, 1'b0)
    cyc();
    `CHK("len0_gnt", bus.d_gnt, 1'b1)
    `CHK("len0_arid", bus.arid, 4'd1)
    `CHK("len0_arlen", bus.arlen, 8'd0)
    cyc();
    bus.arready = 1'b0;
    bus.d_req = 1'b0;
    settle();
    `CHK("len0_rready", bus.rready, 1'b1)
    burst(1'b1, 1, 1, 4'd1, -1, -1, 32'h60);
    `CHK("len0_done", bus.busy, 1'b0)
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 Parameter MAX_STREAK, default 4: maximum consecutive data-side grants while an instruction request is waiting.
REQ-002 aclk  in  1  single clock; all logic samples on its rising edge.
REQ-003 aresetn  in  1  reset, synchronous, active-low.
REQ-004 i_req / i_addr / i_len  in  1/32/8  instruction-side read request; i_len = beats-1 (arlen encoding).
REQ-005 i_gnt  out  1  pulses for one cycle when the instruction-side AR handshake completes.
REQ-006 i_rdata / i_rvalid / i_rlast  out  32/1/1  instruction-side read beat, valid strobe, last-beat flag.
REQ-007 d_req / d_addr / d_len  in  1/32/8  data-side read request, same encoding as REQ-004.
REQ-008 d_gnt, d_rdata, d_rvalid, d_rlast  out  1/32/1/1  data-side equivalents of REQ-005/006.
REQ-009 arid/araddr/arlen/arsize/arburst/arvalid  out  4/32/8/3/2/1  AXI read-address channel; arready  in  1.
REQ-010 rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI read-data channel; rready  out  1.
REQ-011 busy  out  1  high whenever state is not IDLE; err  out  1  one-cycle error pulse.

Function
REQ-012 The block SHALL use a three-state FSM: IDLE, ADDR, DATA.
REQ-013 IDLE: if any request is high, the block SHALL register the winner's addr/len/owner and go to ADDR next cycle; otherwise it SHALL stay in IDLE.
REQ-014 Arbitration: data side SHALL win, except when i_req=1 and streak==MAX_STREAK, in which case the instruction side SHALL win.
REQ-015 streak (3 bits) SHALL increment on a data grant while i_req=1, SHALL clear on an instruction grant or on a data grant with i_req=0, and SHALL saturate at MAX_STREAK.
REQ-016 ADDR: arvalid=1; araddr, arlen and arid SHALL hold stable until arready=1.
REQ-017 In ADDR, arid SHALL be 0 for the instruction owner and 1 for the data owner; arsize SHALL be 3'b010 and arburst SHALL be 2'b01 at all times.
REQ-018 The owner's gnt SHALL be combinational arvalid&arready and SHALL coincide with the handshake cycle; on that handshake the FSM SHALL go to DATA.
REQ-019 DATA: rready=1, arvalid=0; rdata SHALL be routed combinationally to the owner's *_rdata, with *_rvalid=rvalid and *_rlast=rlast; the non-owner's rvalid/rlast SHALL be 0.
REQ-020 On rvalid&rlast in DATA, the FSM SHALL return to IDLE, giving exactly one idle bubble cycle before the next arbitration.
REQ-021 err SHALL pulse for one cycle on any accepted beat with rresp!=0 or rid!=registered arid; data SHALL still be forwarded on that beat.
REQ-022 A requester SHALL hold req, addr and len stable until its gnt and SHALL drop req in the following cycle; a req still high in IDLE SHALL be treated as a new request.
REQ-023 Requests arriving in ADDR/DATA SHALL be ignored until IDLE; only one outstanding transaction SHALL exist at any time.
REQ-024 A burst with arlen=0 SHALL complete on its single beat, which carries rlast=1.

Reset
REQ-025 When aresetn=0 at a rising edge, state SHALL go to IDLE, streak to 0, and araddr, arlen, arid, arvalid and rready to 0.
REQ-026 During reset, all gnt/rvalid/rlast/busy/err outputs SHALL be 0.
REQ-027 Reset mid-burst SHALL abandon the transaction without forwarding further beats; the slave is reset by the same aresetn.

Verification
REQ-028 Single instruction read: i_req, i_addr=0x1FC00000, i_len=7, arready after 2 cycles -> arid=0, arlen=7, one i_gnt pulse, 8 i_rvalid beats with i_rlast on the 8th, then busy=0.
REQ-029 Simultaneous requests: i_req=d_req=1 in IDLE -> data served first (arid=1), then instruction served after one bubble cycle.
REQ-030 Starvation: i_req held, d_req re-asserted continuously -> 4 data grants, then the 5th grant goes to instruction, streak=0.
REQ-031 Error beat: rresp=2'b10 on beat 3 of 4 -> err pulses exactly on that cycle; all 4 beats are still delivered to the owner.
REQ-032 Reset during DATA after 2 of 8 beats -> next edge gives IDLE, rready=0, no further *_rvalid, and a new request is then served normally.
REQ-033 arlen=0 with arready held high -> gnt in the first ADDR cycle, single beat with rlast, return to IDLE.
